// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module      : regfile_pkg
// Description : Shared constants for the ID-stage register file, decode
//               control and immediate generation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int unsigned c_xlen_default = 64;
    localparam int unsigned c_x0_idx       = 0;

    typedef enum logic [6:0] {
        OPC_R_TYPE = 7'b0110011,
        OPC_LD     = 7'b0000011,
        OPC_SD     = 7'b0100011,
        OPC_BEQ    = 7'b1100011
    } opcode_e;

endpackage

`default_nettype wire

// File: rtl/pend_counter.sv
//------------------------------------------------------------------------------
// Module      : pend_counter
// Description : Saturating up/down counter tracking in-flight writes to one
//               architectural register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_count,
    output logic              o_full,
    output logic              o_nonzero
);

    localparam logic [PEND_W-1:0] c_max = '1;

    logic [PEND_W-1:0] r_count;

    // Coincident inc/dec cancel; each direction saturates independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_count <= r_count + PEND_W'(1);
        end else if (i_dec && !i_inc && o_nonzero) begin
            r_count <= r_count - PEND_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_full    = (r_count == c_max);
    assign o_nonzero = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : regfile_scoreboard
// Description : Multi-port register file with write-through bypass, hardwired
//               x0 and per-register pending-write scoreboard for hazard stalls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = c_xlen_default,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int PEND_W = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  wr_retire,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    output logic                  stall,
    input  logic [NREAD-1:0]      rd_use
);

    localparam logic [AW-1:0] c_x0 = AW'(c_x0_idx);

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [PEND_W-1:0] w_cnt  [NREGS];
    logic [NREGS-1:0]  w_full;
    logic [NREGS-1:0]  w_nz;
    logic              w_wr_valid;
    logic              w_retire;
    logic              w_issue_acc;

    assign w_wr_valid  = wr_en && (wr_addr != c_x0);
    assign w_retire    = w_wr_valid && wr_retire;
    assign issue_ready = !reset && !w_full[issue_rd];
    assign w_issue_acc = issue_valid && issue_ready && (issue_rd != c_x0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // x0 has no counter: never busy, never full, so issues to it are no-ops.
    assign w_cnt[0]  = '0;
    assign w_full[0] = 1'b0;
    assign w_nz[0]   = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        pend_counter #(
            .PEND_W(PEND_W)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .i_inc    (w_issue_acc && (issue_rd == AW'(i))),
            .i_dec    (w_retire && (wr_addr == AW'(i))),
            .o_count  (w_cnt[i]),
            .o_full   (w_full[i]),
            .o_nonzero(w_nz[i])
        );
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = rd_addr[k*AW +: AW];
        assign w_hit  = w_wr_valid && (wr_addr == w_addr);

        assign rd_data[k*XLEN +: XLEN] = (w_addr == c_x0) ? '0      :
                                         w_hit            ? wr_data :
                                                            r_regs[w_addr];

        // The last outstanding write retiring now is already bypassed.
        assign rd_busy[k] = w_nz[w_addr] &&
                            !(w_hit && wr_retire && (w_cnt[w_addr] == PEND_W'(1)));
    end

    assign stall = |(rd_use & rd_busy);

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench: directed scenarios plus random traffic
//               against an array-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;
    localparam int PMAX  = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  wr_retire;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_ready;
    logic                  stall;
    logic [NREAD-1:0]      rd_use;

    logic [XLEN-1:0] m_regs [NREGS];
    int              m_cnt  [NREGS];
    int              total = 0;
    int              bad   = 0;

    regfile_scoreboard #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD),
        .PEND_W(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_retire  (wr_retire),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .stall      (stall),
        .rd_use     (rd_use)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic ret_last;
        ret_last = wr_en && wr_retire && wr_addr != 0 && wr_addr == a && m_cnt[a] == 1;
        return (m_cnt[a] != 0) && !ret_last;
    endfunction

    task automatic set_in(input int a0, input int a1, input logic [1:0] use_v,
                          input logic we, input int wa, input logic [63:0] wd,
                          input logic ret, input logic iv, input int ird);
        rd_addr     = {AW'(a1), AW'(a0)};
        rd_use      = use_v;
        wr_en       = we;
        wr_addr     = AW'(wa);
        wr_data     = wd;
        wr_retire   = ret;
        issue_valid = iv;
        issue_rd    = AW'(ird);
    endtask

    // Check all outputs against the model mid-cycle, then advance one edge.
    task automatic step();
        logic [1:0] eb;
        logic       er, acc, rt;
        @(negedge clk);
        eb[0] = exp_busy(rd_addr[0 +: AW]);
        eb[1] = exp_busy(rd_addr[AW +: AW]);
        er    = !reset && (issue_rd == 0 || m_cnt[issue_rd] != PMAX);
        chk("rd_data0", rd_data[0 +: XLEN], exp_read(rd_addr[0 +: AW]));
        chk("rd_data1", rd_data[XLEN +: XLEN], exp_read(rd_addr[AW +: AW]));
        chk("rd_busy", 64'(rd_busy), 64'(eb));
        chk("stall", 64'(stall), 64'(|(eb & rd_use)));
        chk("issue_ready", 64'(issue_ready), 64'(er));
        acc = issue_valid && er && issue_rd != 0;
        rt  = wr_en && wr_retire && wr_addr != 0;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (!(acc && rt && wr_addr == issue_rd)) begin
                if (acc) m_cnt[issue_rd]++;
                if (rt && m_cnt[wr_addr] > 0) m_cnt[wr_addr]--;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // Load registers, then pulse reset and read everything back as zero.
        for (int i = 1; i < 8; i++) begin
            set_in(i, 0, 2'b00, 1, i, 64'h100 + 64'(i), 0, 1, i);
            step();
        end
        reset = 1'b1;
        set_in(3, 4, 2'b11, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i += 2) begin
            set_in(i, i + 1, 2'b11, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Write-through bypass, then the stored value next cycle.
        set_in(5, 1, 2'b00, 1, 5, 64'hDEAD_BEEF, 0, 0, 0);
        #1 chk("bypass_same_cycle", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
        step();
        set_in(5, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        #1 chk("bypass_stored", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
        step();

        // x0 ignores writes and issues.
        set_in(0, 0, 2'b11, 1, 0, 64'h1234, 1, 1, 0);
        #1 chk("x0_bypass", rd_data[XLEN +: XLEN], 64'h0);
        step();
        set_in(0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        #1 chk("x0_busy", 64'(rd_busy), 64'h0);
        step();

        // Fill counter 7, bounce off full, drain.
        for (int i = 0; i < 3; i++) begin
            set_in(7, 0, 2'b01, 0, 0, 0, 0, 1, 7);
            step();
        end
        set_in(7, 0, 2'b01, 0, 0, 0, 0, 1, 7);
        #1 chk("full_not_ready", 64'(issue_ready), 64'h0);
        step();
        set_in(7, 0, 2'b01, 1, 7, 64'h77, 1, 0, 7);
        step();
        set_in(7, 0, 2'b01, 0, 0, 0, 0, 0, 7);
        #1 chk("ready_after_retire", 64'(issue_ready), 64'h1);
        step();
        set_in(7, 0, 2'b01, 1, 7, 64'h78, 1, 0, 0);
        step();
        set_in(7, 0, 2'b01, 1, 7, 64'h79, 1, 0, 0);
        #1 chk("busy_clears_last_retire", 64'(rd_busy[0]), 64'h0);
        step();

        // RAW hazard on x3.
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        step();
        for (int i = 0; i < 2; i++) begin
            set_in(3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
            #1 chk("hazard_stall", 64'(stall), 64'h1);
            step();
        end
        set_in(3, 0, 2'b01, 1, 3, 64'h42, 1, 0, 0);
        #1 chk("hazard_release_stall", 64'(stall), 64'h0);
        chk("hazard_release_data", rd_data[0 +: XLEN], 64'h42);
        step();

        // Simultaneous issue and retire on x9 keeps the count.
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 1, 9);
        step();
        set_in(9, 0, 2'b01, 1, 9, 64'h99, 1, 1, 9);
        step();
        set_in(9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        #1 chk("simul_still_busy", 64'(rd_busy[0]), 64'h1);
        step();
        set_in(9, 0, 2'b01, 1, 9, 64'h9A, 1, 0, 0);
        step();

        // Reset with x10 pending; the late retire saturates but still writes.
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 1, 10);
        step();
        reset = 1'b1;
        set_in(10, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        set_in(10, 0, 2'b01, 1, 10, 64'h55, 1, 0, 0);
        step();
        set_in(10, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        #1 chk("late_wb_data", rd_data[0 +: XLEN], 64'h55);
        chk("late_wb_not_busy", 64'(rd_busy[0]), 64'h0);
        step();

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   2'($urandom), 1'($urandom), $urandom_range(0, 7), {$urandom, $urandom},
                   1'($urandom), 1'($urandom), $urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the decode-stage register file for the pipelined RISC-V core. It provides NREAD combinational read ports, one posedge write port with write-through bypass, and x0 hardwired to zero. A per-register pending-write scoreboard lets decode detect RAW/WAW hazards and stall without re-reading pipeline registers. It sits in ID: read ports feed the ID/EX operand latches, the write port is driven from WB, and the issue port is driven by decode when an instruction with RegWrite leaves ID.

## Interface
Parameters:
- XLEN, 64, register data width
- NREGS, 32, number of architectural registers; must be a power of two, at least 2
- NREAD, 2, number of read ports, at least 1
- PEND_W, 2, width of each per-register pending-write counter
- AW, $clog2(NREGS), register address width; derived, not overridden

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- rd_addr  input  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rd_data  output  NREAD*XLEN  packed read data for each port
- rd_busy  output  NREAD  port k's register has at least one pending write
- wr_en  input  1  writeback valid; corresponds to WB RegWrite
- wr_addr  input  AW  writeback destination
- wr_data  input  XLEN  writeback value
- wr_retire  input  1  this writeback retires a scoreboard entry; low for writes never issued
- issue_valid  input  1  decode requests to issue an instruction writing issue_rd
- issue_rd  input  AW  destination of the issuing instruction
- issue_ready  output  1  the issue is accepted this cycle
- stall  output  1  OR of rd_busy over the ports that decode flags via rd_use
- rd_use  input  NREAD  port k's operand is actually consumed by the instruction in ID

## Operation
- Storage: NREGS x XLEN flops. On reset, every register is cleared to 0 at the next edge.
- Write: at the rising edge, when wr_en is high and wr_addr is not 0, regs[wr_addr] becomes wr_data. Writes to x0 are discarded.
- Read: combinational.
  - rd_addr equal to 0 returns 0.
  - If wr_en is high, wr_addr is not 0, and wr_addr equals rd_addr, the port returns wr_data (write-through bypass). This replaces the old negedge-write scheme.
  - Otherwise the port returns the stored value.
- Scoreboard: one PEND_W-bit counter per register. The counter for x0 is held at 0.
  - Issue handshake: the issue is accepted when issue_valid and issue_ready are both high and issue_rd is not 0. An accepted issue increments cnt[issue_rd].
  - issue_ready is low when cnt[issue_rd] equals 2^PEND_W - 1, and low while reset is high. Otherwise it is high. When issue_rd is 0, issue_ready is high and the issue changes nothing.
  - Retire: when wr_en, wr_retire, and wr_addr not 0 are all true, cnt[wr_addr] decrements. If the counter is already 0 it stays 0.
  - Simultaneous issue and retire on the same register leaves the counter unchanged. On different registers, both updates apply.
- rd_busy[k] = (cnt[rd_addr_k] != 0) and not (a retire targets rd_addr_k this cycle with cnt equal to 1). This means the bypassed value clears the hazard in the same cycle.
- stall = OR over k of (rd_use[k] and rd_busy[k]).

## Timing
- Read path and rd_busy/stall: zero-cycle, combinational from addresses and WB inputs.
- Write becomes architecturally visible in the same cycle via bypass, and from storage in the next cycle.
- A counter increment from an issue accepted in cycle N is visible on rd_busy in cycle N+1.
- Reset outputs: rd_data = 0 for all addresses from the cycle after the reset edge. All counters are 0, so rd_busy = 0 and stall = 0. issue_ready = 0 while reset is high and 1 after reset.
- Reset mid-operation: all counters clear. Late writebacks arriving after reset still write their data. Their retires saturate at 0.
- Wrap: counters never wrap. Overflow is prevented by issue_ready and underflow by saturation.

## Structure
- Shared package regfile_pkg: XLEN default, the x0 index constant, and the RISC-V opcode constants for r_type, ld, sd, and beq. Decode control and immediate generation also import this package.
- One sub-module, pend_counter: a PEND_W-bit saturating up/down counter with inc and dec inputs and full/nonzero outputs. It is instantiated NREGS-1 times in a generate loop.
- Read ports are built with a generate loop over NREAD. No per-port sub-module.

## Test plan
- Reset: load regs through the write port, then pulse reset for 1 cycle -> every rd_data reads 0, rd_busy = 0, and issue_ready is 0 during reset and 1 after.
- Bypass: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF, with rd_addr port0=5 in the same cycle -> rd_data0 = 64'hDEAD_BEEF combinationally. The next cycle with wr_en=0 still reads 64'hDEAD_BEEF.
- x0: write 64'h1234 to x0, issue rd=0 -> reads of x0 return 0 and no busy bit is set. Reads of x0 through all ports return 0.
- Scoreboard: issue rd=7 three times (PEND_W=2) -> counter is 3 and issue_ready=0 for rd=7. Then one retire to 7 -> issue_ready=1. Three retires -> rd_busy clears in the same cycle as the last retire.
- Hazard: issue rd=3, then the next instruction reads x3 with rd_use0=1 -> stall=1 until the WB retire to 3 with wr_data=64'h42. In that cycle stall=0 and rd_data0=64'h42.
- Simultaneous: issue rd=9 and retire wr_addr=9 in the same cycle with cnt[9]=1 -> cnt stays 1. Retire with cnt=0 after a mid-operation reset -> cnt stays 0 and the data is still written.
